wb_sram_slave: RTL and testbench
================================

# wb_sram_slave

Wishbone B4 registered-feedback SRAM target that sits directly downstream of a Wishbone interconnect slave port (`s0`-style). It decodes a local window, serves classic and incrementing/constant-address burst cycles with byte-lane writes, and returns ERR for addresses outside its window. It gives interconnect benches a real memory target with a 1-beat-per-cycle burst path.

## Interface
- `WB_ADDR_WIDTH`, default 32: byte address width.
- `WB_DATA_WIDTH`, default 32: data width; multiple of 8. `NB = WB_DATA_WIDTH/8`.
- `MEM_WORDS`, default 1024: depth in data words; power of 2.
- `BASE_ADDR`, default 'h0: byte address of word 0; aligned to `MEM_WORDS*NB`.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rstn`  in  1  reset, **asynchronous, active-low**.
- `s.ADR`  in  WB_ADDR_WIDTH  byte address; low log2(NB) bits ignored.
- `s.DAT_W`  in  WB_DATA_WIDTH  write data.
- `s.SEL`  in  NB  byte-lane enables.
- `s.CYC`, `s.STB`, `s.WE`  in  1 each  cycle, strobe, write enable.
- `s.CTI`  in  3  000 classic, 001 constant, 010 incrementing, 111 end-of-burst; other codes treated as 000.
- `s.BTE`  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `s.DAT_R`  out  WB_DATA_WIDTH  read data, valid only while ACK=1, else 0.
- `s.ACK`, `s.ERR`  out  1 each  beat terminate, error terminate.

## Operation
- Word index `idx = (ADR - BASE_ADDR) >> log2(NB)`. In range iff `BASE_ADDR <= ADR < BASE_ADDR + MEM_WORDS*NB`.
- States:
  - `IDLE`: ACK=ERR=0.
  - `BEAT`: ACK=1.
  - `HOLD`: burst paused by STB=0; ACK=0.
  - `FAIL`: ERR=1.
- IDLE: edge with CYC&STB:
  - In range: latch `cur=idx`, read mem[idx] into DAT_R, go to BEAT.
  - Out of range: go to FAIL.
- BEAT, edge with CYC&STB (beat completes):
  - If WE: write DAT_W lanes where SEL=1 to mem[cur].
  - CTI=001: stay BEAT; cur unchanged; re-read.
  - CTI=010: stay BEAT; cur=next(cur); read mem[next]. If next is out of range (linear overrun), go to FAIL instead.
  - CTI=000/111/other: go to IDLE.
- next(cur): BTE=00 gives cur+1. BTE=01/10/11 with N=4/8/16 gives `{cur[hi:log2N], cur[log2N-1:0]+1}`, wrapping within the N-aligned block.
- BEAT, edge with CYC&!STB: go to HOLD. No write, cur held.
- HOLD, edge with CYC&STB: re-read mem[cur], go to BEAT.
- FAIL: ERR for exactly one cycle, no write, DAT_R=0, then IDLE. Burst is terminated; master must restart.
- CYC=0 at any edge from any state: go to IDLE, no write.
- Memory contents are not reset and are not initialised.

## Timing
- Reset (async assert): ACK=0, ERR=0, DAT_R=0, state IDLE, cur=0, all immediately. Deassertion is sampled synchronously.
- Classic single: STB sampled at E0, ACK high E0→E1, write at E1, ACK low after E1. Earliest next sample at E2, giving 2 cycles/beat.
- Burst CTI=001/010: first ACK after E0, then ACK held continuously; 1 beat per cycle until CTI=111 beat at edge Ek, after which ACK drops.
- Read data for beat n+1 is fetched at the edge completing beat n. In a constant-address read/write mix, DAT_R shows the pre-write value; DAT_R on write beats is don't-care.
- ACK and ERR are never high together. Neither is high in the cycle after CYC=0 was sampled.
- Reset mid-burst: outputs drop asynchronously. The in-flight beat is not written unless its edge preceded reset assertion.

## Test plan
- Classic write 0xDEADBEEF, SEL=1111, to BASE+0x10; classic read of BASE+0x10 → ACK 1 cycle after STB, DAT_R=0xDEADBEEF, 2 cycles/beat.
- SEL=0010 write of 0x0000AA00 over 0x11223344 → read returns 0x1122AA44.
- Wrap-4 incrementing read from word 6 (CTI 010,010,010,111) → words 6,7,4,5 on 4 consecutive ACK cycles, then ACK=0.
- Linear burst starting at the last word (MEM_WORDS-1): beat 1 ACKs, beat 2 returns ERR for 1 cycle, then idle; no memory write. Separately, a read of BASE+MEM_WORDS*NB → ERR one cycle, DAT_R=0.
- Incrementing burst with STB dropped 2 cycles after beat 2 → ACK low 2 cycles, resumes with beat 3 at the correct address; no skipped or duplicated beats.
- rstn asserted mid-burst → ACK=ERR=DAT_R=0 same cycle; after release, a classic read returns data written before reset.

Source files
------------

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 bus bundle between an interconnect port and the SRAM target.
interface wb_sram_slave_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
);
    localparam int NB = WB_DATA_WIDTH / 8;

    logic [WB_ADDR_WIDTH-1:0] ADR;
    logic [WB_DATA_WIDTH-1:0] DAT_W;
    logic [WB_DATA_WIDTH-1:0] DAT_R;
    logic [NB-1:0]            SEL;
    logic                     CYC;
    logic                     STB;
    logic                     WE;
    logic [2:0]               CTI;
    logic [1:0]               BTE;
    logic                     ACK;
    logic                     ERR;

    modport master (
        output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
        output DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback SRAM target with classic, constant and
// incrementing (linear/wrap) bursts, byte-lane writes and ERR outside its window.
module wb_sram_slave #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_WORDS = 1024,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input logic clk,
    input logic rstn,
    wb_sram_slave_if.slave s
);
    localparam int NB = WB_DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int SW = IW + LB;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] FAIL = 2'd3;

    logic [1:0]               state;
    logic [IW-1:0]            cur;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            nxt;
    logic [IW-1:0]            mask;
    logic [IW-1:0]            rd_addr;
    logic                     in_range;
    logic                     overrun;
    logic                     wr_en;
    logic                     ack;
    logic [WB_DATA_WIDTH-1:0] rdata;
    logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                     unused_ok;

    // window is aligned to its span, so the upper address bits identify it
    assign in_range = (s.ADR >> SW) == (BASE_ADDR >> SW);
    assign idx = s.ADR[SW-1:LB];
    assign unused_ok = &{1'b0, s.ADR};

    always_comb begin
        mask = '1;
        unique case (s.BTE)
            2'b01:   mask = IW'(3);
            2'b10:   mask = IW'(7);
            2'b11:   mask = IW'(15);
            default: mask = '1;
        endcase
        nxt = (cur & ~mask) | ((cur + 1'b1) & mask);
        overrun = (s.BTE == 2'b00) && (cur == {IW{1'b1}});
    end

    // address whose word lands in rdata for the beat after this edge
    always_comb begin
        rd_addr = cur;
        if (state == IDLE) begin
            rd_addr = idx;
        end else if (state == BEAT && s.CTI == 3'b010) begin
            rd_addr = nxt;
        end
    end

    assign wr_en = (state == BEAT) && s.CYC && s.STB && s.WE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cur   <= '0;
        end else if (!s.CYC) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s.STB) begin
                        if (in_range) begin
                            cur   <= idx;
                            state <= BEAT;
                        end else begin
                            state <= FAIL;
                        end
                    end
                end
                BEAT: begin
                    if (!s.STB) begin
                        state <= HOLD;
                    end else begin
                        case (s.CTI)
                            3'b001: state <= BEAT;
                            3'b010: begin
                                if (overrun) begin
                                    state <= FAIL;
                                end else begin
                                    cur <= nxt;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                HOLD: begin
                    if (s.STB) begin
                        state <= BEAT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (s.SEL[b]) begin
                    mem[cur][b*8 +: 8] <= s.DAT_W[b*8 +: 8];
                end
            end
        end
        rdata <= mem[rd_addr];
    end

    assign ack     = (state == BEAT);
    assign s.ACK   = ack;
    assign s.ERR   = (state == FAIL);
    assign s.DAT_R = ack ? rdata : '0;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: vector table plus hand-written
// sequences for STB pause and mid-burst reset.
module tb_wb_sram_slave;
    localparam logic [31:0] B = 32'h0000_1000;

    typedef struct {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        ack;
        logic        err;
        logic        chk;
        logic [31:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vt[$];

    wb_sram_slave_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();

    wb_sram_slave #(
        .WB_ADDR_WIDTH(32),
        .WB_DATA_WIDTH(32),
        .MEM_WORDS(1024),
        .BASE_ADDR(B)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input logic cyc, stb, we, input logic [2:0] cti,
                       input logic [1:0] bte, input logic [31:0] adr, dat,
                       input logic [3:0] sel, input logic ack, err, chk,
                       input logic [31:0] rd);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.cti = cti; v.bte = bte;
        v.adr = adr; v.dat = dat; v.sel = sel;
        v.ack = ack; v.err = err; v.chk = chk; v.rd = rd;
        vt.push_back(v);
    endtask

    task automatic idle();
        add(0, 0, 0, 3'b000, 2'b00, 32'h0, 32'h0, 4'h0, 0, 0, 1, 32'h0);
    endtask

    task automatic tw(input logic [31:0] a, d, input logic [3:0] sl);
        add(1, 1, 1, 3'b000, 2'b00, a, d, sl, 1, 0, 0, 32'h0);
        add(1, 1, 1, 3'b000, 2'b00, a, d, sl, 0, 0, 1, 32'h0);
        idle();
    endtask

    task automatic tr(input logic [31:0] a, exp);
        add(1, 1, 0, 3'b000, 2'b00, a, 32'h0, 4'h0, 1, 0, 1, exp);
        add(1, 1, 0, 3'b000, 2'b00, a, 32'h0, 4'h0, 0, 0, 1, 32'h0);
        idle();
    endtask

    task automatic drv(input logic cyc, stb, we, input logic [2:0] cti,
                       input logic [1:0] bte, input logic [31:0] adr, dat,
                       input logic [3:0] sel);
        bus.CYC = cyc; bus.STB = stb; bus.WE = we; bus.CTI = cti;
        bus.BTE = bte; bus.ADR = adr; bus.DAT_W = dat; bus.SEL = sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic ea, ee, ck,
                         input logic [31:0] ed);
        checks++;
        if (bus.ACK !== ea || bus.ERR !== ee || (ck && bus.DAT_R !== ed)) begin
            errors++;
            $display("FAIL %s: ack=%0b err=%0b dat=%h, want ack=%0b err=%0b dat=%h",
                     nm, bus.ACK, bus.ERR, bus.DAT_R, ea, ee, ed);
        end
    endtask

    initial begin
        drv(0, 0, 0, 3'b000, 2'b00, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 0, 1, 32'h0);
        #3 rstn = 1'b1;

        idle();
        tw(B + 32'h10, 32'hDEAD_BEEF, 4'hF);
        tr(B + 32'h10, 32'hDEAD_BEEF);
        tw(B + 32'h14, 32'h1122_3344, 4'hF);
        tw(B + 32'h14, 32'h0000_AA00, 4'h2);
        tr(B + 32'h14, 32'h1122_AA44);
        tw(B + 32'h18, 32'h6666_6666, 4'hF);
        tw(B + 32'h1C, 32'h7777_7777, 4'hF);
        // wrap-4 from word 6
        add(1, 1, 0, 3'b010, 2'b01, B + 32'h18, 0, 0, 1, 0, 1, 32'h6666_6666);
        add(1, 1, 0, 3'b010, 2'b01, B + 32'h18, 0, 0, 1, 0, 1, 32'h7777_7777);
        add(1, 1, 0, 3'b010, 2'b01, B + 32'h18, 0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        add(1, 1, 0, 3'b010, 2'b01, B + 32'h18, 0, 0, 1, 0, 1, 32'h1122_AA44);
        add(1, 1, 0, 3'b111, 2'b01, B + 32'h18, 0, 0, 0, 0, 1, 32'h0);
        idle();
        // linear overrun from the last word
        tw(B + 32'hFFC, 32'hCAFE_F00D, 4'hF);
        add(1, 1, 0, 3'b010, 2'b00, B + 32'hFFC, 0, 0, 1, 0, 1, 32'hCAFE_F00D);
        add(1, 1, 0, 3'b010, 2'b00, B + 32'hFFC, 0, 0, 0, 1, 1, 32'h0);
        add(1, 1, 0, 3'b010, 2'b00, B + 32'hFFC, 0, 0, 0, 0, 1, 32'h0);
        idle();
        add(1, 1, 0, 3'b000, 2'b00, B + 32'h1000, 0, 0, 0, 1, 1, 32'h0);
        idle();
        add(1, 1, 0, 3'b000, 2'b00, B - 32'h4, 0, 0, 0, 1, 1, 32'h0);
        idle();
        tr(B + 32'hFFC, 32'hCAFE_F00D);
        // constant-address write then read shows pre-write value
        add(1, 1, 1, 3'b001, 2'b00, B + 32'h10, 32'hA5A5_A5A5, 4'hF, 1, 0, 0, 32'h0);
        add(1, 1, 1, 3'b001, 2'b00, B + 32'h10, 32'hA5A5_A5A5, 4'hF, 1, 0, 1, 32'hDEAD_BEEF);
        add(1, 1, 0, 3'b111, 2'b00, B + 32'h10, 0, 0, 0, 0, 1, 32'h0);
        idle();
        tr(B + 32'h10, 32'hA5A5_A5A5);

        for (int i = 0; i < vt.size(); i++) begin
            drv(vt[i].cyc, vt[i].stb, vt[i].we, vt[i].cti, vt[i].bte,
                vt[i].adr, vt[i].dat, vt[i].sel);
            step();
            check($sformatf("vec%0d", i), vt[i].ack, vt[i].err, vt[i].chk, vt[i].rd);
        end

        // linear read from word 4 with STB paused after beat 2
        drv(1, 1, 0, 3'b010, 2'b00, B + 32'h10, 0, 0);
        step(); check("pause_b1", 1, 0, 1, 32'hA5A5_A5A5);
        step(); check("pause_b2", 1, 0, 1, 32'h1122_AA44);
        step(); check("pause_b3a", 1, 0, 1, 32'h6666_6666);
        drv(1, 0, 0, 3'b010, 2'b00, B + 32'h18, 0, 0);
        step(); check("pause_h1", 0, 0, 1, 32'h0);
        step(); check("pause_h2", 0, 0, 1, 32'h0);
        drv(1, 1, 0, 3'b010, 2'b00, B + 32'h18, 0, 0);
        step(); check("pause_b3", 1, 0, 1, 32'h6666_6666);
        step(); check("pause_b4", 1, 0, 1, 32'h7777_7777);
        drv(1, 1, 0, 3'b111, 2'b00, B + 32'h1C, 0, 0);
        step(); check("pause_end", 0, 0, 1, 32'h0);
        drv(0, 0, 0, 3'b000, 2'b00, 0, 0, 0);
        step();

        // reset during a constant burst on word 6; pending write must not land
        drv(1, 1, 0, 3'b001, 2'b00, B + 32'h18, 0, 0);
        step(); check("rst_pre", 1, 0, 1, 32'h6666_6666);
        drv(1, 1, 1, 3'b001, 2'b00, B + 32'h18, 32'hBAD0_BAD0, 4'hF);
        #2 rstn = 1'b0;
        #1 check("rst_async", 0, 0, 1, 32'h0);
        step(); check("rst_hold", 0, 0, 1, 32'h0);
        drv(0, 0, 0, 3'b000, 2'b00, 0, 0, 0);
        step();
        #2 rstn = 1'b1;
        drv(1, 1, 0, 3'b000, 2'b00, B + 32'h18, 0, 0);
        step(); check("rst_read", 1, 0, 1, 32'h6666_6666);
        step(); check("rst_read_end", 0, 0, 1, 32'h0);
        drv(0, 0, 0, 3'b000, 2'b00, 0, 0, 0);
        step(); check("rst_idle", 0, 0, 1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
